alu_op_issue: RTL and testbench
===============================

# alu_op_issue

Issue-side counterpart of the execute-stage ALU: decodes the instruction held in ID into the ALU's control fields (5-bit `ALUCtrl` opcode, `Sign`, operand-source selects, extended immediate) and registers them as the ID/EX pipeline register. It supports stall, flush and bubble insertion, and counts illegal opcodes. The registered outputs drive the ALU and its operand muxes directly in EX.

## Interface
- `ILL_CNT_W`, default 8: width of the saturating illegal-instruction counter.
- `clk` input 1: pipeline clock.
- `reset` input 1: synchronous, active-high.
- `id_inst` input 32: instruction in ID.
- `id_valid` input 1: `id_inst` is a real instruction.
- `stall` input 1: hold the EX register contents.
- `flush` input 1: load a bubble.
- `ex_alu_ctrl` output 5: ALU opcode; ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLL=6, SRL=7, SRA=8, SLT=9.
- `ex_sign` output 1: signed compare select for SLT.
- `ex_src1_sel` output 2: ALU in1 source; 0=rs, 1=zero-extended shamt, 2=constant 16.
- `ex_src2_imm` output 1: 1 selects `ex_imm` as in2, 0 selects rt.
- `ex_imm` output 32: extended immediate.
- `ex_rs` output 5: rs field.
- `ex_rt` output 5: rt field.
- `ex_rd` output 5: destination register.
- `ex_reg_write` output 1: result is written back.
- `ex_valid` output 1: EX slot holds a valid instruction.
- `ill_cnt` output `ILL_CNT_W`: saturating count of illegal instructions.

## Operation
- Decode is combinational from `id_inst`: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- R-type (op 0x00) uses dest=rd and reg_write=1.
  - funct 0x20 add: ADD, sign=1. 0x21 addu: ADD, sign=0.
  - funct 0x22 sub: SUB, sign=1. 0x23 subu: SUB, sign=0.
  - funct 0x24/25/26/27: AND/OR/XOR/NOR.
  - funct 0x2A slt: SLT, sign=1. 0x2B sltu: SLT, sign=0.
  - funct 0x00/02/03 sll/srl/sra: SLL/SRL/SRA with src1_sel=1.
  - funct 0x04/06/07 sllv/srlv/srav: SLL/SRL/SRA with src1_sel=0.
- I-type uses dest=rt, src2_imm=1, reg_write=1.
  - op 0x08 addi: ADD, sign=1. 0x09 addiu: ADD, sign=0. Both sign-extend imm.
  - op 0x0A slti: SLT, sign=1. 0x0B sltiu: SLT, sign=0. Both sign-extend imm.
  - op 0x0C/0D/0E andi/ori/xori: AND/OR/XOR, zero-extended imm.
  - op 0x0F lui: SLL, src1_sel=2, zero-extended imm.
  - op 0x23 lw: ADD, sign-extended imm.
  - op 0x2B sw: ADD, sign-extended imm, reg_write=0.
- Branches: op 0x04 beq and 0x05 bne decode to SUB, src2_imm=0, sign-extended imm, reg_write=0.
- Illegal: any other op/funct combination, including the NOP encoding 0x00000000 (sll r0 counts as legal).
  - An illegal instruction loads a bubble.
  - `ill_cnt` increments only on a load-enabled cycle (`id_valid`=1, no stall, no flush), saturating at all-ones.
- Bubble value: all outputs 0 except `ill_cnt`. This is ADD, reg_write=0, valid=0.
- Register update priority per cycle: `reset` > `flush` > `stall` > load.
  - reset: bubble, `ill_cnt`=0.
  - flush: bubble, even if `stall`=1.
  - stall: hold all EX fields; `ill_cnt` unchanged.
  - load: decoded fields with `ex_valid`=`id_valid` & legal; `id_valid`=0 loads a bubble.

## Timing
- Latency: 1 cycle. Decode sampled at posedge k appears on outputs after posedge k.
- Reset value of every output is 0, including `ill_cnt`.
- `stall` and `flush` are sampled at the same edge as `id_inst`.
- A stall of any length holds outputs bit-exact; the first non-stall edge loads the current `id_inst`.
- `flush` with `stall`: the bubble is loaded and subsequent stall cycles hold the bubble.
- `reset` asserted mid-stream clears the register and counter on that edge; any concurrent `flush` or `stall` is ignored.
- `ill_cnt` saturation: at all-ones a further illegal load leaves the value unchanged. There is no wrap to 0.

## Test plan
- Reset/bubble: hold `reset` 2 cycles with `id_inst`=0x014B4820 (add). Required: all outputs 0. After release, one edge gives `ex_alu_ctrl`=0, `ex_sign`=1, `ex_rd`=9, `ex_reg_write`=1, `ex_valid`=1.
- Full decode sweep: every legal op/funct in turn, 1 per cycle. Required: outputs match the Operation bullets one cycle later.
  - sra 0x00031883: SRA=8, src1_sel=1, rd=3.
  - lui 0x3C011234: SLL=6, src1_sel=2, imm=0x00001234, rt=1.
  - slti imm 0x8000: SLT, sign=1, imm=0xFFFF8000.
  - andi imm 0x8000: AND, imm=0x00008000.
- Stall then flush: load add, stall 3 cycles while `id_inst` changes. Required: outputs unchanged. Then assert `flush` and `stall` together. Required: bubble, `ex_valid`=0.
- Illegal counting: send op 0x3F ×3 with valid=1. Required: bubbles, `ill_cnt`=3. Send the same with `stall`=1. Required: count stays 3.
- Saturation: with `ILL_CNT_W`=2, send 5 illegal instructions. Required: `ill_cnt` goes 1, 2, 3, 3, 3.
- Reset mid-stream: `reset` pulsed with `stall`=1 while holding sw. Required: outputs and `ill_cnt` are 0 the next cycle; the next load decodes normally.

Source files
------------

// File: rtl/alu_op_issue_if.sv
// rtl/alu_op_issue_if.sv - ID-side inputs and ID/EX register outputs of the ALU issue stage
interface alu_op_issue_if #(
    parameter int ILL_CNT_W = 8
) ();
    logic [31:0]          id_inst;
    logic                 id_valid;
    logic                 stall;
    logic                 flush;
    logic [4:0]           ex_alu_ctrl;
    logic                 ex_sign;
    logic [1:0]           ex_src1_sel;
    logic                 ex_src2_imm;
    logic [31:0]          ex_imm;
    logic [4:0]           ex_rs;
    logic [4:0]           ex_rt;
    logic [4:0]           ex_rd;
    logic                 ex_reg_write;
    logic                 ex_valid;
    logic [ILL_CNT_W-1:0] ill_cnt;

    modport master (
        output id_inst, id_valid, stall, flush,
        input  ex_alu_ctrl, ex_sign, ex_src1_sel, ex_src2_imm, ex_imm,
        input  ex_rs, ex_rt, ex_rd, ex_reg_write, ex_valid, ill_cnt
    );

    modport slave (
        input  id_inst, id_valid, stall, flush,
        output ex_alu_ctrl, ex_sign, ex_src1_sel, ex_src2_imm, ex_imm,
        output ex_rs, ex_rt, ex_rd, ex_reg_write, ex_valid, ill_cnt
    );
endinterface

// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - ALU control decode and ID/EX pipeline register with illegal-op counter
module alu_op_issue #(
    parameter int ILL_CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    alu_op_issue_if.slave    bus
);

    typedef struct packed {
        logic [4:0]  alu_ctrl;
        logic        sign;
        logic [1:0]  src1_sel;
        logic        src2_imm;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_write;
        logic        valid;
    } ex_t;

    // A bubble is the all-zero word: ADD, no writeback, not valid.
    localparam ex_t BUBBLE = '0;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_XOR = 5'd4;
    localparam logic [4:0] ALU_NOR = 5'd5;
    localparam logic [4:0] ALU_SLL = 5'd6;
    localparam logic [4:0] ALU_SRL = 5'd7;
    localparam logic [4:0] ALU_SRA = 5'd8;
    localparam logic [4:0] ALU_SLT = 5'd9;

    ex_t                  ex_d, ex_q;
    logic [ILL_CNT_W-1:0] ill_cnt_d, ill_cnt_q;

    ex_t         dec;
    logic        dec_legal;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    // Combinational decode of the ID instruction into ALU control fields.
    always_comb begin
        op        = bus.id_inst[31:26];
        funct     = bus.id_inst[5:0];
        imm_sext  = {{16{bus.id_inst[15]}}, bus.id_inst[15:0]};
        imm_zext  = {16'h0000, bus.id_inst[15:0]};
        dec       = BUBBLE;
        dec_legal = 1'b0;
        dec.rs    = bus.id_inst[25:21];
        dec.rt    = bus.id_inst[20:16];
        dec.valid = 1'b1;
        if (op == 6'h00) begin
            dec.rd        = bus.id_inst[15:11];
            dec.reg_write = 1'b1;
            dec_legal     = 1'b1;
            case (funct)
                6'h20: begin dec.alu_ctrl = ALU_ADD; dec.sign = 1'b1; end
                6'h21: dec.alu_ctrl = ALU_ADD;
                6'h22: begin dec.alu_ctrl = ALU_SUB; dec.sign = 1'b1; end
                6'h23: dec.alu_ctrl = ALU_SUB;
                6'h24: dec.alu_ctrl = ALU_AND;
                6'h25: dec.alu_ctrl = ALU_OR;
                6'h26: dec.alu_ctrl = ALU_XOR;
                6'h27: dec.alu_ctrl = ALU_NOR;
                6'h2A: begin dec.alu_ctrl = ALU_SLT; dec.sign = 1'b1; end
                6'h2B: dec.alu_ctrl = ALU_SLT;
                6'h00: begin dec.alu_ctrl = ALU_SLL; dec.src1_sel = 2'd1; end
                6'h02: begin dec.alu_ctrl = ALU_SRL; dec.src1_sel = 2'd1; end
                6'h03: begin dec.alu_ctrl = ALU_SRA; dec.src1_sel = 2'd1; end
                6'h04: dec.alu_ctrl = ALU_SLL;
                6'h06: dec.alu_ctrl = ALU_SRL;
                6'h07: dec.alu_ctrl = ALU_SRA;
                default: dec_legal = 1'b0;
            endcase
            // The all-zero word is the NOP encoding and is treated as illegal.
            if (bus.id_inst == 32'h0000_0000) begin
                dec_legal = 1'b0;
            end
        end else begin
            dec.rd        = bus.id_inst[20:16];
            dec.src2_imm  = 1'b1;
            dec.reg_write = 1'b1;
            dec.imm       = imm_sext;
            dec_legal     = 1'b1;
            case (op)
                6'h08: begin dec.alu_ctrl = ALU_ADD; dec.sign = 1'b1; end
                6'h09: dec.alu_ctrl = ALU_ADD;
                6'h0A: begin dec.alu_ctrl = ALU_SLT; dec.sign = 1'b1; end
                6'h0B: dec.alu_ctrl = ALU_SLT;
                6'h0C: begin dec.alu_ctrl = ALU_AND; dec.imm = imm_zext; end
                6'h0D: begin dec.alu_ctrl = ALU_OR;  dec.imm = imm_zext; end
                6'h0E: begin dec.alu_ctrl = ALU_XOR; dec.imm = imm_zext; end
                6'h0F: begin
                    dec.alu_ctrl = ALU_SLL;
                    dec.src1_sel = 2'd2;
                    dec.imm      = imm_zext;
                end
                6'h23: dec.alu_ctrl = ALU_ADD;
                6'h2B: begin dec.alu_ctrl = ALU_ADD; dec.reg_write = 1'b0; end
                6'h04, 6'h05: begin
                    // Branch compare: rs - rt, no destination.
                    dec.alu_ctrl  = ALU_SUB;
                    dec.src2_imm  = 1'b0;
                    dec.reg_write = 1'b0;
                    dec.rd        = 5'd0;
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // Next EX register contents: flush beats stall beats load; counter saturates.
    always_comb begin
        ex_d      = ex_q;
        ill_cnt_d = ill_cnt_q;
        if (bus.flush) begin
            ex_d = BUBBLE;
        end else if (!bus.stall) begin
            if (bus.id_valid && dec_legal) begin
                ex_d = dec;
            end else begin
                ex_d = BUBBLE;
            end
            if (bus.id_valid && !dec_legal && (ill_cnt_q != '1)) begin
                ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
            end
        end
    end

    // ID/EX register and illegal counter; reset overrides flush and stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q      <= BUBBLE;
            ill_cnt_q <= '0;
        end else begin
            ex_q      <= ex_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign bus.ex_alu_ctrl  = ex_q.alu_ctrl;
    assign bus.ex_sign      = ex_q.sign;
    assign bus.ex_src1_sel  = ex_q.src1_sel;
    assign bus.ex_src2_imm  = ex_q.src2_imm;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rs        = ex_q.rs;
    assign bus.ex_rt        = ex_q.rt;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_reg_write = ex_q.reg_write;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ill_cnt      = ill_cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - self-checking bench for alu_op_issue with a reference decode model
module tb_alu_op_issue;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_op_issue_if #(.ILL_CNT_W(8)) ifa ();
    alu_op_issue_if #(.ILL_CNT_W(2)) ifb ();

    alu_op_issue #(.ILL_CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    alu_op_issue #(.ILL_CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    typedef struct {
        logic [4:0]  ctrl;
        logic        sign;
        logic [1:0]  s1;
        logic        s2;
        logic [31:0] imm;
        logic [4:0]  rs, rt, rd;
        logic        rw, v;
        bit          imm_dc, rd_dc;
    } exp_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t m;
    int   mcnt  = 0;
    int   mcnt2 = 0;

    byte unsigned rfun [16] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                                8'h2A, 8'h2B, 8'h00, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07};
    byte unsigned iops [14] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                                8'h23, 8'h2B, 8'h04, 8'h05, 8'h04, 8'h23};

    function automatic exp_t bubble_e();
        exp_t e;
        e.ctrl = 0; e.sign = 0; e.s1 = 0; e.s2 = 0; e.imm = 0;
        e.rs = 0; e.rt = 0; e.rd = 0; e.rw = 0; e.v = 0;
        e.imm_dc = 0; e.rd_dc = 0;
        return e;
    endfunction

    // Reference: instruction table from the ISA description.
    function automatic void ref_decode(input logic [31:0] inst, output bit legal, output exp_t e);
        logic [31:0] sx;
        logic [31:0] zx;
        sx = {{16{inst[15]}}, inst[15:0]};
        zx = {16'h0, inst[15:0]};
        e = bubble_e();
        e.rs = inst[25:21];
        e.rt = inst[20:16];
        e.v  = 1;
        legal = 1;
        if (inst[31:26] == 6'h00) begin
            e.rd = inst[15:11]; e.rw = 1; e.imm_dc = 1;
            case (inst[5:0])
                6'h20: begin e.ctrl = 0; e.sign = 1; end
                6'h21: e.ctrl = 0;
                6'h22: begin e.ctrl = 1; e.sign = 1; end
                6'h23: e.ctrl = 1;
                6'h24: e.ctrl = 2;
                6'h25: e.ctrl = 3;
                6'h26: e.ctrl = 4;
                6'h27: e.ctrl = 5;
                6'h2A: begin e.ctrl = 9; e.sign = 1; end
                6'h2B: e.ctrl = 9;
                6'h00: begin e.ctrl = 6; e.s1 = 1; end
                6'h02: begin e.ctrl = 7; e.s1 = 1; end
                6'h03: begin e.ctrl = 8; e.s1 = 1; end
                6'h04: e.ctrl = 6;
                6'h06: e.ctrl = 7;
                6'h07: e.ctrl = 8;
                default: legal = 0;
            endcase
            if (inst == 0) legal = 0;
        end else begin
            e.rd = inst[20:16]; e.s2 = 1; e.rw = 1; e.imm = sx;
            case (inst[31:26])
                6'h08: begin e.ctrl = 0; e.sign = 1; end
                6'h09: e.ctrl = 0;
                6'h0A: begin e.ctrl = 9; e.sign = 1; end
                6'h0B: e.ctrl = 9;
                6'h0C: begin e.ctrl = 2; e.imm = zx; end
                6'h0D: begin e.ctrl = 3; e.imm = zx; end
                6'h0E: begin e.ctrl = 4; e.imm = zx; end
                6'h0F: begin e.ctrl = 6; e.s1 = 2; e.imm = zx; end
                6'h23: e.ctrl = 0;
                6'h2B: begin e.ctrl = 0; e.rw = 0; end
                6'h04, 6'h05: begin e.ctrl = 1; e.s2 = 0; e.rw = 0; e.rd_dc = 1; end
                default: legal = 0;
            endcase
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("alu_ctrl", 32'(ifa.ex_alu_ctrl), 32'(m.ctrl));
        chk("sign", 32'(ifa.ex_sign), 32'(m.sign));
        chk("src1_sel", 32'(ifa.ex_src1_sel), 32'(m.s1));
        chk("src2_imm", 32'(ifa.ex_src2_imm), 32'(m.s2));
        if (!m.imm_dc) chk("imm", ifa.ex_imm, m.imm);
        chk("rs", 32'(ifa.ex_rs), 32'(m.rs));
        chk("rt", 32'(ifa.ex_rt), 32'(m.rt));
        if (!m.rd_dc) chk("rd", 32'(ifa.ex_rd), 32'(m.rd));
        chk("reg_write", 32'(ifa.ex_reg_write), 32'(m.rw));
        chk("valid", 32'(ifa.ex_valid), 32'(m.v));
        chk("ill_cnt", 32'(ifa.ill_cnt), 32'(mcnt));
        chk("ill_cnt_w2", 32'(ifb.ill_cnt), 32'(mcnt2));
        chk("valid_w2", 32'(ifb.ex_valid), 32'(m.v));
    endtask

    // Drive one cycle, advance the model by the priority rules, then compare.
    task automatic step(input logic [31:0] inst, input logic v, input logic st,
                        input logic fl, input logic rs);
        bit   legal;
        exp_t d;
        ifa.id_inst = inst; ifa.id_valid = v; ifa.stall = st; ifa.flush = fl;
        ifb.id_inst = inst; ifb.id_valid = v; ifb.stall = st; ifb.flush = fl;
        reset = rs;
        @(posedge clk);
        ref_decode(inst, legal, d);
        if (rs) begin
            m = bubble_e(); mcnt = 0; mcnt2 = 0;
        end else if (fl) begin
            m = bubble_e();
        end else if (!st) begin
            m = (v && legal) ? d : bubble_e();
            if (v && !legal) begin
                if (mcnt < 255) mcnt++;
                if (mcnt2 < 3) mcnt2++;
            end
        end
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] x;
        int          k;
        x = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4)      x = {6'h00, x[25:6], rfun[$urandom_range(0, 15)][5:0]};
        else if (k < 8) x = {iops[$urandom_range(0, 13)][5:0], x[25:0]};
        else if (k == 9) x[31:26] = 6'h00;
        return x;
    endfunction

    initial begin
        logic [31:0] add_i;
        int          exp2 [5];
        add_i = 32'h014B_4820;
        exp2 = '{1, 2, 3, 3, 3};
        m = bubble_e();

        step(add_i, 1, 0, 0, 1);
        step(add_i, 1, 0, 0, 1);
        chk("rst_valid", 32'(ifa.ex_valid), 0);
        chk("rst_imm", ifa.ex_imm, 0);
        chk("rst_cnt", 32'(ifa.ill_cnt), 0);
        step(add_i, 1, 0, 0, 0);
        chk("add_ctrl", 32'(ifa.ex_alu_ctrl), 0);
        chk("add_sign", 32'(ifa.ex_sign), 1);
        chk("add_rd", 32'(ifa.ex_rd), 9);
        chk("add_rw", 32'(ifa.ex_reg_write), 1);
        chk("add_valid", 32'(ifa.ex_valid), 1);

        for (int i = 0; i < 16; i++) step({6'h00, 20'($urandom), rfun[i][5:0]}, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step({iops[i][5:0], 26'($urandom)}, 1, 0, 0, 0);
        step(32'h0000_0040, 1, 0, 0, 0);
        chk("sll_r0_valid", 32'(ifa.ex_valid), 1);
        step(32'h0003_1883, 1, 0, 0, 0);
        chk("sra_ctrl", 32'(ifa.ex_alu_ctrl), 8);
        chk("sra_src1", 32'(ifa.ex_src1_sel), 1);
        chk("sra_rd", 32'(ifa.ex_rd), 3);
        step(32'h3C01_1234, 1, 0, 0, 0);
        chk("lui_ctrl", 32'(ifa.ex_alu_ctrl), 6);
        chk("lui_src1", 32'(ifa.ex_src1_sel), 2);
        chk("lui_imm", ifa.ex_imm, 32'h0000_1234);
        chk("lui_rt", 32'(ifa.ex_rt), 1);
        step(32'h2822_8000, 1, 0, 0, 0);
        chk("slti_ctrl", 32'(ifa.ex_alu_ctrl), 9);
        chk("slti_sign", 32'(ifa.ex_sign), 1);
        chk("slti_imm", ifa.ex_imm, 32'hFFFF_8000);
        step(32'h3022_8000, 1, 0, 0, 0);
        chk("andi_ctrl", 32'(ifa.ex_alu_ctrl), 2);
        chk("andi_imm", ifa.ex_imm, 32'h0000_8000);

        step(add_i, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(rnd_inst(), 1, 1, 0, 0);
        chk("stall_rd", 32'(ifa.ex_rd), 9);
        chk("stall_valid", 32'(ifa.ex_valid), 1);
        step(add_i, 1, 1, 1, 0);
        chk("flush_valid", 32'(ifa.ex_valid), 0);
        step(add_i, 1, 1, 0, 0);
        chk("flush_hold", 32'(ifa.ex_reg_write), 0);

        for (int i = 0; i < 3; i++) step(32'hFC00_0000, 1, 0, 0, 0);
        chk("ill_cnt3", 32'(ifa.ill_cnt), 3);
        for (int i = 0; i < 3; i++) step(32'hFC00_0000, 1, 1, 0, 0);
        chk("ill_cnt3_stall", 32'(ifa.ill_cnt), 3);
        step(32'h0000_0000, 1, 0, 0, 0);
        chk("nop_cnt", 32'(ifa.ill_cnt), 4);

        step(add_i, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(32'hFC00_0000, 1, 0, 0, 0);
            chk("sat_w2", 32'(ifb.ill_cnt), 32'(exp2[i]));
        end

        step(32'hAC45_0010, 1, 0, 0, 0);
        step(32'hAC45_0010, 1, 1, 1, 1);
        chk("mid_rst_valid", 32'(ifa.ex_valid), 0);
        chk("mid_rst_cnt", 32'(ifa.ill_cnt), 0);
        step(32'hAC45_0010, 1, 0, 0, 0);
        chk("sw_valid", 32'(ifa.ex_valid), 1);
        chk("sw_rw", 32'(ifa.ex_reg_write), 0);
        chk("sw_imm", ifa.ex_imm, 32'h0000_0010);

        for (int i = 0; i < 400; i++) begin
            step(rnd_inst(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
